// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: encodings, overflow constants and decoded-op record for the ALU issue port
package alu_issue_pkg;
   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_BNE   = 5'b00010;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_BLT   = 5'b00110;
   localparam logic [4:0] ALU_ADD  = 5'd0;
   localparam logic [4:0] ALU_SUB  = 5'd1;
   localparam logic [4:0] ALU_AND  = 5'd2;
   localparam logic [4:0] ALU_OR   = 5'd3;
   localparam logic [4:0] ALU_SLL  = 5'd4;
   localparam logic [4:0] ALU_SRA  = 5'd5;
   localparam logic [4:0] RSTATUS_REG = 5'd30;
   localparam logic [31:0] OVF_ADD  = 32'd1;
   localparam logic [31:0] OVF_ADDI = 32'd2;
   localparam logic [31:0] OVF_SUB  = 32'd3;
   typedef enum logic [2:0] {K_ALU, K_ADDI, K_BNE, K_BLT, K_ILL} kind_t;
   typedef struct packed {
      logic [31:0] opa;
      logic [31:0] opb;
      logic [31:0] imm;
      logic [4:0]  aluop;
      logic [4:0]  shamt;
      logic [4:0]  rd;
      logic        we;
      kind_t       kind;
   } dec_t;
endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational instruction + operand decode into an ALU request
module alu_issue_decode
   import alu_issue_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output dec_t        dec
);
   logic [4:0] op;
   logic [4:0] fn;
   assign op = instr[31:27];
   assign fn = instr[6:2];
   always_comb begin
      dec = '0;
      dec.rd = instr[26:22];
      dec.imm = {{15{instr[16]}}, instr[16:0]};
      dec.kind = K_ILL;
      if (op == OP_RTYPE && fn <= ALU_SRA) begin
         dec.kind = K_ALU;
         dec.opa = rs_val;
         dec.opb = rt_val;
         dec.aluop = fn;
         dec.shamt = instr[11:7];
         dec.we = 1'b1;
      end else if (op == OP_ADDI) begin
         dec.kind = K_ADDI;
         dec.opa = rs_val;
         dec.opb = {{15{instr[16]}}, instr[16:0]};
         dec.aluop = ALU_ADD;
         dec.we = 1'b1;
      end else if (op == OP_BNE || op == OP_BLT) begin
         // branches compare the rd register value (carried on rt_val) against rs
         dec.kind = op == OP_BNE ? K_BNE : K_BLT;
         dec.opa = rt_val;
         dec.opb = rs_val;
         dec.aluop = ALU_SUB;
      end
   end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: two-stage issue/result pipeline driving an external combinational ALU
module alu_issue_ctrl
   import alu_issue_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_rs_val,
   input  logic [31:0] in_rt_val,
   output logic [31:0] alu_operandA,
   output logic [31:0] alu_operandB,
   output logic [4:0]  alu_opcode,
   output logic [4:0]  alu_shamt,
   input  logic [31:0] alu_result,
   input  logic        alu_neq,
   input  logic        alu_lt,
   input  logic        alu_ovf,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_we,
   output logic [4:0]  out_rd,
   output logic [31:0] out_data,
   output logic        out_branch_taken,
   output logic [31:0] out_imm,
   output logic        out_illegal
);
   dec_t dec, s1;
   logic s1_valid, adv, ovf_hit;
   logic [31:0] ovf_val;
   alu_issue_decode u_dec (.instr(in_instr), .rs_val(in_rs_val), .rt_val(in_rt_val), .dec(dec));
   assign adv = s1_valid && (!out_valid || out_ready);
   assign in_ready = !s1_valid || adv;
   assign alu_operandA = s1_valid ? s1.opa : '0;
   assign alu_operandB = s1_valid ? s1.opb : '0;
   assign alu_opcode = s1_valid ? s1.aluop : '0;
   assign alu_shamt = s1_valid ? s1.shamt : '0;
   // only add/addi/sub report overflow; logic ops and branch compares ignore the flag
   assign ovf_hit = alu_ovf && (s1.kind == K_ADDI ||
                    (s1.kind == K_ALU && (s1.aluop == ALU_ADD || s1.aluop == ALU_SUB)));
   assign ovf_val = s1.kind == K_ADDI ? OVF_ADDI : s1.aluop == ALU_SUB ? OVF_SUB : OVF_ADD;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1 <= '0;
         out_valid <= 1'b0;
         out_we <= 1'b0;
         out_rd <= '0;
         out_data <= '0;
         out_branch_taken <= 1'b0;
         out_imm <= '0;
         out_illegal <= 1'b0;
      end else begin
         if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) s1 <= dec;
         end
         if (adv) begin
            out_valid <= 1'b1;
            out_we <= ovf_hit || (s1.we && s1.rd != 5'd0);
            out_rd <= ovf_hit ? RSTATUS_REG : s1.rd;
            out_data <= ovf_hit ? ovf_val : alu_result;
            out_branch_taken <= s1.kind == K_BNE ? alu_neq : s1.kind == K_BLT ? alu_lt : 1'b0;
            out_imm <= s1.imm;
            out_illegal <= s1.kind == K_ILL;
         end else if (out_ready) out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed + randomized-backpressure scoreboard bench with a behavioural ALU
module tb_alu_issue_ctrl;
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0, in_ready;
   logic [31:0] in_instr = '0, in_rs_val = '0, in_rt_val = '0;
   logic [31:0] alu_operandA, alu_operandB, alu_result;
   logic [4:0]  alu_opcode, alu_shamt;
   logic        alu_neq, alu_lt, alu_ovf;
   logic        out_valid, out_ready = 1'b1, out_we, out_branch_taken, out_illegal;
   logic [4:0]  out_rd;
   logic [31:0] out_data, out_imm;

   typedef struct packed {
      logic we; logic [4:0] rd; logic [31:0] data; logic taken; logic [31:0] imm; logic ill;
   } exp_t;

   exp_t q[$];
   int passed = 0, total = 0;
   logic acc, rnd = 1'b0, prev_stall = 1'b0;
   logic [71:0] snap;

   alu_issue_ctrl dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
      .alu_operandA(alu_operandA), .alu_operandB(alu_operandB), .alu_opcode(alu_opcode),
      .alu_shamt(alu_shamt), .alu_result(alu_result), .alu_neq(alu_neq), .alu_lt(alu_lt),
      .alu_ovf(alu_ovf), .out_valid(out_valid), .out_ready(out_ready), .out_we(out_we),
      .out_rd(out_rd), .out_data(out_data), .out_branch_taken(out_branch_taken),
      .out_imm(out_imm), .out_illegal(out_illegal));

   always #5 clock = ~clock;

   // behavioural stand-in for the external combinational ALU
   logic [31:0] sum, dif;
   assign sum = alu_operandA + alu_operandB;
   assign dif = alu_operandA - alu_operandB;
   assign alu_neq = alu_operandA != alu_operandB;
   assign alu_lt = $signed(alu_operandA) < $signed(alu_operandB);
   always_comb begin
      alu_result = '0;
      alu_ovf = 1'b0;
      case (alu_opcode)
         5'd0: begin alu_result = sum; alu_ovf = (alu_operandA[31] == alu_operandB[31]) && (sum[31] != alu_operandA[31]); end
         5'd1: begin alu_result = dif; alu_ovf = (alu_operandA[31] != alu_operandB[31]) && (dif[31] != alu_operandA[31]); end
         5'd2: alu_result = alu_operandA & alu_operandB;
         5'd3: alu_result = alu_operandA | alu_operandB;
         5'd4: alu_result = alu_operandA << alu_shamt;
         5'd5: alu_result = $signed(alu_operandA) >>> alu_shamt;
         default: alu_result = '0;
      endcase
   end

   function automatic exp_t model(logic [31:0] ins, logic [31:0] rs, logic [31:0] rt);
      exp_t e;
      logic [4:0] op, f, sh;
      logic [31:0] imm, r;
      logic ov, wr;
      op = ins[31:27]; f = ins[6:2]; sh = ins[11:7];
      imm = {{15{ins[16]}}, ins[16:0]};
      e = '0; e.rd = ins[26:22]; e.imm = imm; r = '0; ov = 1'b0; wr = 1'b0;
      if (op == 5'd0 && f <= 5'd5) begin
         wr = 1'b1;
         case (f)
            5'd0: begin r = rs + rt; ov = (rs[31] == rt[31]) && (r[31] != rs[31]); end
            5'd1: begin r = rs - rt; ov = (rs[31] != rt[31]) && (r[31] != rs[31]); end
            5'd2: r = rs & rt;
            5'd3: r = rs | rt;
            5'd4: r = rs << sh;
            default: r = $signed(rs) >>> sh;
         endcase
         if (ov) r = f == 5'd0 ? 32'd1 : 32'd3;
      end else if (op == 5'd5) begin
         wr = 1'b1;
         r = rs + imm;
         ov = (rs[31] == imm[31]) && (r[31] != rs[31]);
         if (ov) r = 32'd2;
      end else if (op == 5'd2) e.taken = rt != rs;
      else if (op == 5'd6) e.taken = $signed(rt) < $signed(rs);
      else e.ill = 1'b1;
      e.we = ov || (wr && e.rd != 5'd0);
      e.rd = ov ? 5'd30 : e.rd;
      e.data = r;
      return e;
   endfunction

   function automatic logic [31:0] rt_ins(logic [4:0] rd, logic [4:0] sh, logic [4:0] f);
      return {5'd0, rd, 5'd1, 5'd2, sh, f, 2'b00};
   endfunction

   function automatic logic [31:0] mk(logic [4:0] op, logic [4:0] rd, logic [16:0] low);
      return {op, rd, 5'd1, low};
   endfunction

   task automatic chk(string tag, logic [79:0] obs, logic [79:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic sample();
      exp_t e;
      logic [71:0] v;
      v = {out_we, out_rd, out_data, out_branch_taken, out_imm, out_illegal};
      if (prev_stall) chk("hold", 80'({out_valid, v}), 80'({1'b1, snap}));
      if (out_valid && out_ready) begin
         if (q.size() == 0) chk("spurious_out", 80'(1), 80'(0));
         else begin
            e = q.pop_front();
            chk("we", 80'(out_we), 80'(e.we));
            if (e.we) chk("rd", 80'(out_rd), 80'(e.rd));
            if (e.we) chk("data", 80'(out_data), 80'(e.data));
            chk("taken", 80'(out_branch_taken), 80'(e.taken));
            chk("imm", 80'(out_imm), 80'(e.imm));
            chk("illegal", 80'(out_illegal), 80'(e.ill));
         end
      end
      acc = in_valid && in_ready;
      if (acc) q.push_back(model(in_instr, in_rs_val, in_rt_val));
      prev_stall = out_valid && !out_ready;
      snap = v;
   endtask

   task automatic tick();
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      if (reset_n) sample();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(logic [31:0] ins, logic [31:0] rs, logic [31:0] rt);
      in_instr = ins; in_rs_val = rs; in_rt_val = rt; in_valid = 1'b1;
      acc = 1'b0;
      for (int k = 0; k < 50 && !acc; k++) tick();
      if (!acc) chk("accept_timeout", 80'(0), 80'(1));
      in_valid = 1'b0;
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int k = 0; k < 200 && q.size() > 0; k++) tick();
      chk("drain_empty", 80'(q.size()), 80'(0));
   endtask

   initial begin
      #2;
      chk("rst_out_valid", 80'(out_valid), 80'(0));
      chk("rst_outs", 80'({out_we, out_rd, out_data, out_imm, out_illegal, out_branch_taken}), 80'(0));
      chk("rst_alu", 80'({alu_operandA, alu_operandB, alu_opcode, alu_shamt}), 80'(0));
      @(posedge clock); #1;
      reset_n = 1'b1;
      chk("in_ready_after_rst", 80'(in_ready), 80'(1));

      issue(rt_ins(5'd3, 5'd0, 5'd0), 32'd5, 32'd7);
      chk("s1_opcode", 80'(alu_opcode), 80'(0));
      chk("s1_operands", 80'({alu_operandA, alu_operandB}), 80'({32'd5, 32'd7}));
      chk("lat_1clk", 80'(out_valid), 80'(0));
      tick();
      chk("lat_2clk", 80'(out_valid), 80'(1));
      tick();

      issue(rt_ins(5'd3, 5'd0, 5'd0), 32'h7FFFFFFF, 32'd1);
      issue(rt_ins(5'd4, 5'd0, 5'd1), 32'h80000000, 32'd1);
      issue(mk(5'b00101, 5'd6, 17'd1), 32'h7FFFFFFF, 32'd0);
      issue(rt_ins(5'd0, 5'd0, 5'd0), 32'd9, 32'd9);
      issue(mk(5'b00010, 5'd7, 17'd0), 32'd4, 32'd4);
      issue(mk(5'b00010, 5'd7, 17'd3), 32'd4, 32'd5);
      issue(mk(5'b00110, 5'd8, 17'h1FFFF), 32'd3, 32'hFFFFFFFE);
      issue(mk(5'b00110, 5'd8, 17'd2), 32'd1, 32'h80000000);
      issue(rt_ins(5'd5, 5'd4, 5'd4), 32'd1, 32'd0);
      issue(rt_ins(5'd9, 5'd3, 5'd5), 32'hF0000000, 32'd0);
      issue(rt_ins(5'd10, 5'd0, 5'd2), 32'hFF00FF00, 32'h0F0F0F0F);
      issue(rt_ins(5'd11, 5'd0, 5'd3), 32'hFF000000, 32'h000000FF);
      issue(rt_ins(5'd12, 5'd0, 5'b01100), 32'd1, 32'd2);
      issue(mk(5'b11111, 5'd13, 17'd0), 32'd1, 32'd2);
      drain();

      rnd = 1'b1;
      for (int i = 0; i < 8; i++)
         issue(rt_ins(5'(i + 1), 5'($urandom_range(0, 31)), 5'(i % 6)), $urandom, $urandom);
      issue(mk(5'b00101, 5'd14, 17'($urandom)), $urandom, 32'd0);
      drain();
      rnd = 1'b0;

      out_ready = 1'b0;
      issue(rt_ins(5'd15, 5'd0, 5'd0), 32'd1, 32'd2);
      issue(rt_ins(5'd16, 5'd0, 5'd0), 32'd3, 32'd4);
      tick();
      reset_n = 1'b0;
      #1;
      chk("async_rst_valid", 80'(out_valid), 80'(0));
      chk("async_rst_outs", 80'({out_we, out_rd, out_data, out_imm}), 80'(0));
      chk("async_rst_alu", 80'({alu_operandA, alu_opcode}), 80'(0));
      chk("async_rst_ready", 80'(in_ready), 80'(1));
      q.delete();
      prev_stall = 1'b0;
      out_ready = 1'b1;
      @(posedge clock); #1;
      reset_n = 1'b1;
      issue(rt_ins(5'd17, 5'd0, 5'd0), 32'd20, 32'd22);
      chk("post_rst_lat_1clk", 80'(out_valid), 80'(0));
      tick();
      chk("post_rst_lat_2clk", 80'(out_valid), 80'(1));
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
